// File: rtl/vga_bounce_box.sv
// ----------------------------------------------------------------------------
// vga_bounce_box
//   Pixel generator for VGA_Sync. A solid BOX_SIZE x BOX_SIZE box moves STEP
//   pixels per frame on each axis and bounces off the edges of the active
//   area. The box colour advances on every wall hit. A 1-pixel white border
//   frames the active area over a flat background. RGB is registered, giving
//   exactly one cycle of latency from the coordinate inputs.
//
// Ports
//   iCLK          in   1   pixel clock
//   rst           in   1   synchronous active-high reset
//   pixel_count   in   10  current x coordinate
//   line_count    in   10  current y coordinate
//   video_on      in   1   high inside the active area
//   VGA_V_SYNC    in   1   vertical sync, active low
//   stop          in   1   freezes motion; drawing continues
//   red           out  10  red level
//   green         out  10  green level
//   blue          out  10  blue level
//   bounce_count  out  8   wall hits, wraps modulo 256
// ----------------------------------------------------------------------------
module vga_bounce_box #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned STEP     = 2,
    parameter logic [9:0]  BG_COLOR = 10'h040
) (
    input  logic       iCLK,
    input  logic       rst,
    input  logic [9:0] pixel_count,
    input  logic [9:0] line_count,
    input  logic       video_on,
    input  logic       VGA_V_SYNC,
    input  logic       stop,
    output logic [9:0] red,
    output logic [9:0] green,
    output logic [9:0] blue,
    output logic [7:0] bounce_count
);

    // Motion limits and drawing constants, all widened to 11 bits so that
    // position +/- STEP and position + BOX_SIZE never wrap.
    localparam logic [10:0] C_LX     = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] C_LY     = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] C_STEP   = 11'(STEP);
    localparam logic [10:0] C_BOX    = 11'(BOX_SIZE);
    localparam logic [9:0]  C_H_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  C_V_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  C_WHITE  = 10'h3FF;
    localparam logic [9:0]  C_GREY   = 10'h200;

    // State
    logic       r_vs_d;
    logic [9:0] r_x_pos;
    logic [9:0] r_y_pos;
    logic       r_dir_x;      // 0: moving +, 1: moving -
    logic       r_dir_y;
    logic [2:0] r_color_idx;
    logic [7:0] r_bounce;
    logic [9:0] r_red;
    logic [9:0] r_green;
    logic [9:0] r_blue;

    // Combinational
    logic        w_tick;
    logic        w_adv;
    logic [11:0] w_x_nxt;     // {hit, dir, pos}
    logic [11:0] w_y_nxt;
    logic        w_hit;
    logic        w_border;
    logic        w_in_box;
    logic [10:0] w_px;
    logic [10:0] w_py;
    logic [10:0] w_x_lo;
    logic [10:0] w_y_lo;
    logic [10:0] w_x_hi;
    logic [10:0] w_y_hi;
    logic [9:0]  w_box_r;
    logic [9:0]  w_box_g;
    logic [9:0]  w_box_b;
    logic [9:0]  w_red;
    logic [9:0]  w_green;
    logic [9:0]  w_blue;

    // One axis of motion. Returns {hit, new_dir, new_pos}.
    function automatic logic [11:0] axis_next(
        input logic [9:0]  pos,
        input logic        dir_neg,
        input logic [10:0] limit
    );
        logic [10:0] pos_ext;
        logic [10:0] pos_inc;
        logic [11:0] res;
        pos_ext = {1'b0, pos};
        pos_inc = pos_ext + C_STEP;
        if (!dir_neg) begin
            if (pos_inc >= limit) begin
                res = {1'b1, 1'b1, limit[9:0]};
            end else begin
                res = {1'b0, 1'b0, pos_inc[9:0]};
            end
        end else begin
            if (pos_ext <= C_STEP) begin
                res = {1'b1, 1'b0, 10'd0};
            end else begin
                res = {1'b0, 1'b1, pos - C_STEP[9:0]};
            end
        end
        return res;
    endfunction

    // Frame tick on the falling edge of vsync; motion only when not stopped.
    assign w_tick  = r_vs_d & ~VGA_V_SYNC;
    assign w_adv   = w_tick & ~stop;

    assign w_x_nxt = axis_next(r_x_pos, r_dir_x, C_LX);
    assign w_y_nxt = axis_next(r_y_pos, r_dir_y, C_LY);
    // A corner hit counts once.
    assign w_hit   = w_x_nxt[11] | w_y_nxt[11];

    // Drawing decode
    assign w_px   = {1'b0, pixel_count};
    assign w_py   = {1'b0, line_count};
    assign w_x_lo = {1'b0, r_x_pos};
    assign w_y_lo = {1'b0, r_y_pos};
    assign w_x_hi = w_x_lo + C_BOX;
    assign w_y_hi = w_y_lo + C_BOX;

    assign w_border = (pixel_count == 10'd0) || (pixel_count == C_H_LAST) ||
                      (line_count == 10'd0)  || (line_count == C_V_LAST);
    assign w_in_box = (w_px >= w_x_lo) && (w_px < w_x_hi) &&
                      (w_py >= w_y_lo) && (w_py < w_y_hi);

    // Colour index 0 would be black on black-ish background, so show grey.
    always_comb begin
        if (r_color_idx == 3'd0) begin
            w_box_r = C_GREY;
            w_box_g = C_GREY;
            w_box_b = C_GREY;
        end else begin
            w_box_r = {10{r_color_idx[2]}};
            w_box_g = {10{r_color_idx[1]}};
            w_box_b = {10{r_color_idx[0]}};
        end
    end

    // Priority: blanking gate, border, box, background.
    always_comb begin
        w_red   = BG_COLOR;
        w_green = BG_COLOR;
        w_blue  = BG_COLOR;
        if (!video_on) begin
            w_red   = 10'd0;
            w_green = 10'd0;
            w_blue  = 10'd0;
        end else if (w_border) begin
            w_red   = C_WHITE;
            w_green = C_WHITE;
            w_blue  = C_WHITE;
        end else if (w_in_box) begin
            w_red   = w_box_r;
            w_green = w_box_g;
            w_blue  = w_box_b;
        end
    end

    always_ff @(posedge iCLK) begin
        if (rst) begin
            r_vs_d      <= 1'b1;
            r_x_pos     <= 10'd0;
            r_y_pos     <= 10'd0;
            r_dir_x     <= 1'b0;
            r_dir_y     <= 1'b0;
            r_color_idx <= 3'd0;
            r_bounce    <= 8'd0;
            r_red       <= 10'd0;
            r_green     <= 10'd0;
            r_blue      <= 10'd0;
        end else begin
            r_vs_d  <= VGA_V_SYNC;
            r_red   <= w_red;
            r_green <= w_green;
            r_blue  <= w_blue;
            if (w_adv) begin
                r_x_pos <= w_x_nxt[9:0];
                r_dir_x <= w_x_nxt[10];
                r_y_pos <= w_y_nxt[9:0];
                r_dir_y <= w_y_nxt[10];
                if (w_hit) begin
                    r_bounce    <= r_bounce + 8'd1;
                    r_color_idx <= r_color_idx + 3'd1;
                end
            end
        end
    end

    assign red          = r_red;
    assign green        = r_green;
    assign blue         = r_blue;
    assign bounce_count = r_bounce;

endmodule

// File: tb/tb_vga_bounce_box.sv
// ----------------------------------------------------------------------------
// tb_vga_bounce_box
//   Self-checking bench for vga_bounce_box. Reference positions and hit counts
//   come from a closed-form triangle-wave model of the bouncing box, indexed
//   by the number of effective frame ticks since reset.
// ----------------------------------------------------------------------------
module tb_vga_bounce_box;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int BX = 32;
    localparam int ST = 2;
    localparam int LX = H - BX;
    localparam int LY = V - BX;

    logic       iCLK = 1'b0;
    logic       rst;
    logic [9:0] pixel_count;
    logic [9:0] line_count;
    logic       video_on;
    logic       VGA_V_SYNC;
    logic       stop;
    logic [9:0] red;
    logic [9:0] green;
    logic [9:0] blue;
    logic [7:0] bounce_count;

    int checks = 0;
    int errors = 0;
    int n_ticks = 0;   // effective (non-stopped) ticks since reset

    vga_bounce_box dut (
        .iCLK        (iCLK),
        .rst         (rst),
        .pixel_count (pixel_count),
        .line_count  (line_count),
        .video_on    (video_on),
        .VGA_V_SYNC  (VGA_V_SYNC),
        .stop        (stop),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .bounce_count(bounce_count)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        int         x;
        int         y;
        logic       von;
        logic [29:0] exp_rgb;
    } vec_t;

    vec_t vecs[12];

    // ---------------- model ----------------
    function automatic int gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Box bounces like a triangle wave between 0 and lim.
    function automatic int tri_pos(input int n, input int lim);
        int p;
        p = (n * ST) % (2 * lim);
        return (p <= lim) ? p : 2 * lim - p;
    endfunction

    // Ticks on which an axis reaches a wall are multiples of lim/ST; a tick
    // where both axes hit is counted once.
    function automatic int hits(input int n);
        int px;
        int py;
        int pl;
        px = LX / ST;
        py = LY / ST;
        pl = px / gcd(px, py) * py;
        return n / px + n / py - n / pl;
    endfunction

    function automatic logic [29:0] model_rgb(input int x, input int y, input logic von,
                                               input int n);
        int mx;
        int my;
        int ci;
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        mx = tri_pos(n, LX);
        my = tri_pos(n, LY);
        ci = hits(n) % 8;
        if (!von) return 30'd0;
        if (x == 0 || x == H - 1 || y == 0 || y == V - 1) return {3{10'h3FF}};
        if (x >= mx && x < mx + BX && y >= my && y < my + BX) begin
            if (ci == 0) return {3{10'h200}};
            r = ((ci / 4) % 2 == 1) ? 10'h3FF : 10'h000;
            g = ((ci / 2) % 2 == 1) ? 10'h3FF : 10'h000;
            b = (ci % 2 == 1) ? 10'h3FF : 10'h000;
            return {r, g, b};
        end
        return {3{10'h040}};
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic check(input string nm, input logic [29:0] act, input logic [29:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp_v);
        end
    endtask

    task automatic pix(input int x, input int y, input logic von, input string nm);
        pixel_count = 10'(x);
        line_count  = 10'(y);
        video_on    = von;
        step();
        check(nm, {red, green, blue}, model_rgb(x, y, von, n_ticks));
    endtask

    task automatic do_tick();
        video_on   = 1'b0;
        VGA_V_SYNC = 1'b0;
        step();
        VGA_V_SYNC = 1'b1;
        step();
        if (!stop) n_ticks++;
    endtask

    initial begin
        int iter;
        int x;
        int y;
        logic von;

        vecs[0]  = '{5,   5,   1'b1, {3{10'h200}}};
        vecs[1]  = '{5,   5,   1'b0, 30'd0};
        vecs[2]  = '{0,   100, 1'b1, {3{10'h3FF}}};
        vecs[3]  = '{0,   0,   1'b1, {3{10'h3FF}}};
        vecs[4]  = '{31,  31,  1'b1, {3{10'h200}}};
        vecs[5]  = '{32,  31,  1'b1, {3{10'h040}}};
        vecs[6]  = '{31,  32,  1'b1, {3{10'h040}}};
        vecs[7]  = '{639, 200, 1'b1, {3{10'h3FF}}};
        vecs[8]  = '{100, 479, 1'b1, {3{10'h3FF}}};
        vecs[9]  = '{320, 240, 1'b1, {3{10'h040}}};
        vecs[10] = '{700, 500, 1'b0, 30'd0};
        vecs[11] = '{1,   1,   1'b1, {3{10'h200}}};

        rst         = 1'b1;
        VGA_V_SYNC  = 1'b1;
        stop        = 1'b0;
        video_on    = 1'b1;
        pixel_count = 10'd5;
        line_count  = 10'd5;
        repeat (3) step();
        check("reset_rgb", {red, green, blue}, 30'd0);
        check("reset_bounce", {22'd0, bounce_count}, 30'd0);
        rst = 1'b0;

        // Frame 0 table: box grey at (0,0)
        for (int i = 0; i < 12; i++) begin
            pixel_count = 10'(vecs[i].x);
            line_count  = 10'(vecs[i].y);
            video_on    = vecs[i].von;
            step();
            check($sformatf("vec%0d", i), {red, green, blue}, vecs[i].exp_rgb);
        end

        // Latency: border value must not appear before the next edge
        pixel_count = 10'd50;
        line_count  = 10'd50;
        video_on    = 1'b0;
        step();
        pixel_count = 10'd0;
        line_count  = 10'd100;
        video_on    = 1'b1;
        #2;
        check("latency_hold", {red, green, blue}, 30'd0);
        step();
        check("latency_n1", {red, green, blue}, {3{10'h3FF}});

        // Motion: 10 ticks
        repeat (10) do_tick();
        pix(20, 20, 1'b1, "motion_box");
        check("motion_box_const", {red, green, blue}, {3{10'h200}});
        pix(19, 40, 1'b1, "motion_bg");
        check("motion_bg_const", {red, green, blue}, {3{10'h040}});

        // Stop: motion frozen, drawing continues
        stop = 1'b1;
        repeat (5) do_tick();
        pix(20, 20, 1'b0, "stop_gate");
        pix(20, 20, 1'b1, "stop_box");
        check("stop_box_const", {red, green, blue}, {3{10'h200}});
        pix(52, 52, 1'b1, "stop_bg");
        check("stop_bounce", {22'd0, bounce_count}, 30'd0);
        stop = 1'b0;

        // Mid-line reset
        pix(25, 25, 1'b1, "pre_rst");
        rst = 1'b1;
        step();
        check("midrst_rgb", {red, green, blue}, 30'd0);
        rst = 1'b0;
        n_ticks = 0;
        step();
        check("midrst_resume", {red, green, blue}, model_rgb(25, 25, 1'b1, 0));
        pix(21, 21, 1'b1, "midrst_pos");

        // Long randomized run: covers X/Y wall hits and a corner hit
        iter = 0;
        while (n_ticks < 4300 && iter < 6000) begin
            iter++;
            stop = ($urandom_range(0, 7) == 0);
            do_tick();
            check("bounce", {22'd0, bounce_count}, 30'(hits(n_ticks) % 256));
            if (!stop && n_ticks == 4256)
                check("corner_once", {22'd0, bounce_count},
                      30'((hits(n_ticks - 1) + 1) % 256));
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    x = $urandom_range(0, 799);
                    y = $urandom_range(0, 524);
                end else begin
                    x = tri_pos(n_ticks, LX) + $urandom_range(0, BX + 3) - 2;
                    y = tri_pos(n_ticks, LY) + $urandom_range(0, BX + 3) - 2;
                    if (x < 0) x = 0;
                    if (y < 0) y = 0;
                end
                von = ($urandom_range(0, 7) != 0);
                pix(x, y, von, "rand_pix");
            end
        end
        stop = 1'b0;
        if (n_ticks < 4300) begin
            errors++;
            $display("FAIL run_budget got %0d want %0d", n_ticks, 4300);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
